// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle logic/arith/shift ops,
// iterative shift-add multiply and restoring divide/remainder, one operation in flight.
module alu_mc #(
  parameter  int WIDTH = 32,
  localparam int SH_W  = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_alu_a,
  input  logic [WIDTH-1:0] i_alu_b,
  input  logic [4:0]       i_alu_op,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_alu_out,
  output logic             o_zero,
  output logic             o_ovf,
  output logic             o_bad_op
);

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_SUB  = 5'h02;
  localparam logic [4:0] OP_AND  = 5'h03;
  localparam logic [4:0] OP_OR   = 5'h04;
  localparam logic [4:0] OP_XOR  = 5'h05;
  localparam logic [4:0] OP_NOR  = 5'h06;
  localparam logic [4:0] OP_SLT  = 5'h07;
  localparam logic [4:0] OP_SLTU = 5'h08;
  localparam logic [4:0] OP_SLL  = 5'h09;
  localparam logic [4:0] OP_SRL  = 5'h0A;
  localparam logic [4:0] OP_SRA  = 5'h0B;
  localparam logic [4:0] OP_MUL  = 5'h0C;
  localparam logic [4:0] OP_DIVU = 5'h0D;
  localparam logic [4:0] OP_REMU = 5'h0E;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  logic [SH_W:0]    r_cnt;
  logic [4:0]       r_op;
  logic [WIDTH-1:0] r_a;    // multiplicand (MUL) or divisor (DIVU/REMU)
  logic [WIDTH-1:0] r_q;    // multiplier (MUL) or dividend/quotient (DIVU/REMU)
  logic [WIDTH-1:0] r_acc;  // partial product or partial remainder
  logic [WIDTH-1:0] r_alu_out;
  logic             r_zero;
  logic             r_ovf;
  logic             r_bad_op;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SH_W-1:0]  w_sh;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_bad;
  logic             w_multi;

  always_comb begin
    w_sum  = i_alu_a + i_alu_b;
    w_diff = i_alu_a - i_alu_b;
    w_sh   = i_alu_b[SH_W-1:0];
    w_res  = '0;
    w_ovf  = 1'b0;
    w_bad  = 1'b0;
    case (i_alu_op)
      OP_NOP:  w_res = '0;
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (i_alu_a[WIDTH-1] == i_alu_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_alu_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (i_alu_a[WIDTH-1] != i_alu_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_alu_a[WIDTH-1]);
      end
      OP_AND:  w_res = i_alu_a & i_alu_b;
      OP_OR:   w_res = i_alu_a | i_alu_b;
      OP_XOR:  w_res = i_alu_a ^ i_alu_b;
      OP_NOR:  w_res = ~(i_alu_a | i_alu_b);
      OP_SLT:  w_res = WIDTH'($signed(i_alu_a) < $signed(i_alu_b));
      OP_SLTU: w_res = WIDTH'(i_alu_a < i_alu_b);
      OP_SLL:  w_res = i_alu_a << w_sh;
      OP_SRL:  w_res = i_alu_a >> w_sh;
      OP_SRA:  w_res = $unsigned($signed(i_alu_a) >>> w_sh);
      OP_MUL, OP_DIVU, OP_REMU: w_res = '0;
      default: w_bad = 1'b1;
    endcase
  end

  assign w_multi = (i_alu_op == OP_MUL) || (i_alu_op == OP_DIVU) || (i_alu_op == OP_REMU);

  // One iteration of the multiply and divide datapaths.
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]   w_div_sh;
  logic [WIDTH:0]   w_div_trial;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_step_res;

  always_comb begin
    w_mul_acc   = r_acc + (r_q[0] ? r_a : '0);
    w_div_sh    = {r_acc, r_q[WIDTH-1]};
    w_div_trial = w_div_sh - {1'b0, r_a};
    // A zero divisor always "fits", giving all-ones quotient and the dividend as remainder.
    w_div_ge    = (w_div_sh >= {1'b0, r_a});
    w_rem_next  = w_div_ge ? w_div_trial[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
    w_quo_next  = {r_q[WIDTH-2:0], w_div_ge};
    case (r_op)
      OP_MUL:  w_step_res = w_mul_acc;
      OP_DIVU: w_step_res = w_quo_next;
      default: w_step_res = w_rem_next;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_acc     <= '0;
      r_alu_out <= '0;
      r_zero    <= 1'b0;
      r_ovf     <= 1'b0;
      r_bad_op  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_op <= i_alu_op;
            if (w_multi) begin
              r_a     <= (i_alu_op == OP_MUL) ? i_alu_a : i_alu_b;
              r_q     <= (i_alu_op == OP_MUL) ? i_alu_b : i_alu_a;
              r_acc   <= '0;
              r_cnt   <= (SH_W+1)'(WIDTH);
              r_state <= S_BUSY;
            end else begin
              r_alu_out <= w_res;
              r_zero    <= (w_res == '0);
              r_ovf     <= w_ovf;
              r_bad_op  <= w_bad;
              r_state   <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_op == OP_MUL) begin
            r_acc <= w_mul_acc;
            r_a   <= r_a << 1;
            r_q   <= r_q >> 1;
          end else begin
            r_acc <= w_rem_next;
            r_q   <= w_quo_next;
          end
          if (r_cnt == (SH_W+1)'(1)) begin
            r_alu_out <= w_step_res;
            r_zero    <= (w_step_res == '0);
            r_ovf     <= 1'b0;
            r_bad_op  <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_IDLE) && i_rst_n;
  assign o_out_valid = (r_state == S_DONE);
  assign o_alu_out   = r_alu_out;
  assign o_zero      = r_zero;
  assign o_ovf       = r_ovf;
  assign o_bad_op    = r_bad_op;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed and random operations scored against an
// arithmetic reference model, plus handshake timing, hold and reset-abort scenarios.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_out;
  logic        zero;
  logic        ovf;
  logic        bad_op;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  alu_mc #(.WIDTH(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_alu_a     (alu_a),
    .i_alu_b     (alu_b),
    .i_alu_op    (alu_op),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_alu_out   (alu_out),
    .o_zero      (zero),
    .o_ovf       (ovf),
    .o_bad_op    (bad_op)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference result {alu_out, zero, ovf, bad_op} from the opcode definitions.
  function automatic logic [34:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    logic        bad;
    longint      s;
    logic [63:0] p;
    int          sh;
    r = 32'h0; v = 1'b0; bad = 1'b0; sh = int'(b[4:0]);
    case (op)
      5'h00: r = 32'h0;
      5'h01: begin s = longint'($signed(a)) + longint'($signed(b)); r = s[31:0]; v = (s != longint'($signed(r))); end
      5'h02: begin s = longint'($signed(a)) - longint'($signed(b)); r = s[31:0]; v = (s != longint'($signed(r))); end
      5'h03: r = a & b;
      5'h04: r = a | b;
      5'h05: r = a ^ b;
      5'h06: r = ~(a | b);
      5'h07: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'h08: r = (a < b) ? 32'd1 : 32'd0;
      5'h09: r = a << sh;
      5'h0A: r = a >> sh;
      5'h0B: r = $unsigned($signed(a) >>> sh);
      5'h0C: begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
      5'h0D: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'h0E: r = (b == 0) ? a : a % b;
      default: bad = 1'b1;
    endcase
    return {r, (r == 32'h0), v, bad};
  endfunction

  function automatic int exp_lat(input logic [4:0] op);
    return (op >= 5'h0C && op <= 5'h0E) ? 33 : 1;
  endfunction

  // Drives one transaction from IDLE through the output handshake and reports what it saw.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit keep_valid, input int hold,
                       output logic [34:0] obs, output int lat, output int busy_rdy,
                       output int hold_chg, output logic post_rdy, output logic post_vld,
                       output int t_acc);
    int n;
    alu_op = op; alu_a = a; alu_b = b; in_valid = 1'b1;
    busy_rdy = 0; hold_chg = 0;
    @(posedge clk); #1;
    t_acc = cyc;
    in_valid = keep_valid;
    alu_a = $urandom; alu_b = $urandom; alu_op = 5'($urandom_range(0, 31));
    n = 0; lat = -1;
    while (n < 100 && !out_valid) begin
      if (in_ready) busy_rdy++;
      @(posedge clk); #1;
      n++;
    end
    if (out_valid) lat = n + 1;
    if (in_ready) busy_rdy++;
    in_valid = 1'b0;
    obs = {alu_out, zero, ovf, bad_op};
    repeat (hold) begin
      @(posedge clk); #1;
      if ({alu_out, zero, ovf, bad_op} !== obs || out_valid !== 1'b1) hold_chg++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    post_rdy = in_ready;
    post_vld = out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_a = '0; alu_b = '0; alu_op = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, alu_out, zero, ovf, bad_op} !== 36'h0) begin
      n_fail++; $display("FAIL reset_outputs got %h expected 0", {out_valid, alu_out, zero, ovf, bad_op});
    end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b expected 0", in_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b expected 1", in_ready); end
    $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
  endtask

  task automatic test_directed();
    logic [4:0]  ops [12] = '{5'h01, 5'h02, 5'h0B, 5'h09, 5'h07, 5'h08, 5'h0D, 5'h0E, 5'h0D, 5'h0E, 5'h02, 5'h0A};
    logic [31:0] as  [12] = '{32'h7FFF_FFFF, 32'd5, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd100, 32'd100, 32'd9, 32'd9, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] bs  [12] = '{32'd1, 32'd5, 32'h24, 32'd31, 32'd1, 32'd1,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'd1, 32'h20};
    logic [34:0] obs, expv;
    int lat, br, hc, ta;
    logic pr, pv;
    for (int i = 0; i < 12; i++) begin
      issue(ops[i], as[i], bs[i], 1'b0, 0, obs, lat, br, hc, pr, pv, ta);
      expv = model(ops[i], as[i], bs[i]);
      $display("directed op=%h a=%h b=%h out=%h z=%b v=%b bad=%b lat=%0d",
               ops[i], as[i], bs[i], obs[34:3], obs[2], obs[1], obs[0], lat);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL directed_result op=%h got %h expected %h", ops[i], obs, expv);
      end
      n_checks++;
      if (lat !== exp_lat(ops[i])) begin
        n_fail++; $display("FAIL directed_latency op=%h got %0d expected %0d", ops[i], lat, exp_lat(ops[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [34:0] obs, expv;
    int lat, br, hc, ta;
    logic pr, pv;
    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 31));
      if (i % 3 == 0) op = 5'($urandom_range(12, 14));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      issue(op, a, b, 1'b0, 0, obs, lat, br, hc, pr, pv, ta);
      expv = model(op, a, b);
      $display("random op=%h a=%h b=%h out=%h z=%b v=%b bad=%b lat=%0d",
               op, a, b, obs[34:3], obs[2], obs[1], obs[0], lat);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL random_result op=%h a=%h b=%h got %h expected %h", op, a, b, obs, expv);
      end
      n_checks++;
      if (lat !== exp_lat(op) || br !== 0) begin
        n_fail++; $display("FAIL random_timing op=%h lat=%0d busy_ready=%0d expected lat=%0d busy_ready=0",
                           op, lat, br, exp_lat(op));
      end
    end
  endtask

  task automatic test_mul_timing();
    logic [34:0] obs;
    int lat, br, hc, ta;
    logic pr, pv;
    issue(5'h0C, 32'hFFFF_FFFF, 32'd3, 1'b1, 0, obs, lat, br, hc, pr, pv, ta);
    $display("mul_timing out=%h lat=%0d busy_ready=%0d post_ready=%b", obs[34:3], lat, br, pr);
    n_checks++;
    if (obs !== {32'hFFFF_FFFD, 3'b000}) begin n_fail++; $display("FAIL mul_result got %h expected %h", obs, {32'hFFFF_FFFD, 3'b000}); end
    n_checks++;
    if (lat !== 33) begin n_fail++; $display("FAIL mul_latency got %0d expected 33", lat); end
    n_checks++;
    if (br !== 0) begin n_fail++; $display("FAIL mul_in_ready_busy got %0d high cycles expected 0", br); end
    n_checks++;
    if (pr !== 1'b1 || pv !== 1'b0) begin n_fail++; $display("FAIL mul_release got ready=%b valid=%b expected 1 0", pr, pv); end
  endtask

  task automatic test_hold();
    logic [34:0] obs;
    int lat, br, hc, ta;
    logic pr, pv;
    issue(5'h15, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 5, obs, lat, br, hc, pr, pv, ta);
    $display("hold op=15 out=%h bad=%b lat=%0d changes=%0d post_ready=%b", obs[34:3], obs[0], lat, hc, pr);
    n_checks++;
    if (obs !== {32'h0, 3'b101} || lat !== 1) begin
      n_fail++; $display("FAIL bad_op_result got %h lat=%0d expected %h lat=1", obs, lat, {32'h0, 3'b101});
    end
    n_checks++;
    if (hc !== 0) begin n_fail++; $display("FAIL hold_stable got %0d changes expected 0", hc); end
    n_checks++;
    if (pr !== 1'b1 || pv !== 1'b0) begin n_fail++; $display("FAIL hold_release got ready=%b valid=%b expected 1 0", pr, pv); end
  endtask

  task automatic test_back_to_back();
    logic [34:0] obs;
    int lat, br, hc, ta, prev;
    logic pr, pv;
    logic [31:0] a, b;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      issue(5'(i + 3), a, b, 1'b0, 0, obs, lat, br, hc, pr, pv, ta);
      $display("back_to_back op=%h out=%h accept_cycle=%0d", 5'(i + 3), obs[34:3], ta);
      n_checks++;
      if (obs !== model(5'(i + 3), a, b)) begin
        n_fail++; $display("FAIL b2b_result got %h expected %h", obs, model(5'(i + 3), a, b));
      end
      if (prev >= 0) begin
        n_checks++;
        if (ta - prev !== 2) begin n_fail++; $display("FAIL b2b_spacing got %0d cycles expected 2", ta - prev); end
      end
      prev = ta;
    end
  endtask

  task automatic test_reset_abort();
    logic [34:0] obs;
    int lat, br, hc, ta, seen;
    logic pr, pv;
    alu_op = 5'h0C; alu_a = 32'd123457; alu_b = 32'd98765; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready_in_reset got %b expected 0", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || alu_out !== 32'h0) begin
      n_fail++; $display("FAIL abort_cleared got valid=%b out=%h expected 0 0", out_valid, alu_out);
    end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready got %b expected 1", in_ready); end
    seen = 0;
    repeat (40) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL abort_no_valid got %0d valid cycles expected 0", seen); end
    issue(5'h01, 32'd2, 32'd3, 1'b0, 0, obs, lat, br, hc, pr, pv, ta);
    $display("reset_abort: stray_valid=%0d then ADD 2+3 out=%h lat=%0d", seen, obs[34:3], lat);
    n_checks++;
    if (obs !== {32'd5, 3'b000} || lat !== 1) begin
      n_fail++; $display("FAIL abort_next_add got %h lat=%0d expected %h lat=1", obs, lat, {32'd5, 3'b000});
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul_timing();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, multi-cycle successor to the lab-2 combinational ALU, used as the execute-stage arithmetic unit in the register-file/datapath labs. It keeps the seven existing ALU opcodes and adds compare, shift, and iterative multiply/divide/remainder operations. Operands and results move through valid/ready handshakes. The block holds one operation at a time: accept, compute (1 or WIDTH cycles), then present a result until it is consumed.

## Interface
- WIDTH, 32, datapath width; power of two, minimum 8
- SH_W, $clog2(WIDTH), shift-amount width (derived; do not override)
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  operand/opcode presented
- in_ready  out  1  block can accept (high only in IDLE)
- alu_a  in  WIDTH  operand A
- alu_b  in  WIDTH  operand B; low SH_W bits give the shift amount
- alu_op  in  5  opcode
- out_valid  out  1  result registered and stable
- out_ready  in  1  consumer takes the result
- alu_out  out  WIDTH  result
- zero  out  1  alu_out == 0
- ovf  out  1  signed overflow (ADD/SUB only, else 0)
- bad_op  out  1  opcode was undefined

## Operation
- Opcodes:
  - 00 NOP → 0; 01 ADD; 02 SUB; 03 AND; 04 OR; 05 XOR; 06 NOR.
  - 07 SLT (signed a<b → 1, else 0); 08 SLTU (unsigned).
  - 09 SLL; 0A SRL; 0B SRA. Shift amount is alu_b[SH_W-1:0].
  - 0C MUL: low WIDTH bits of a*b, iterative shift-add.
  - 0D DIVU: unsigned quotient; 0E REMU: unsigned remainder; both restoring division.
  - 0F–1F: alu_out=0, bad_op=1, completed as a single-cycle op.
- ADD/SUB wrap modulo 2^WIDTH. ovf = operand signs match (B inverted for SUB) and the result sign differs.
- Divide by zero: DIVU → all ones; REMU → alu_a. bad_op stays 0.
- alu_a, alu_b and alu_op are latched at accept. Input changes after accept have no effect.
- FSM states IDLE, BUSY, DONE:
  - IDLE: in_ready=1. If in_valid is high, the op is accepted at the edge.
    - Single-cycle op (00–0B, undefined): result registered, next state DONE.
    - Multi-cycle op (0C–0E): working registers loaded, cnt ← WIDTH, next state BUSY.
  - BUSY: one multiply/divide step per cycle, cnt decrements. The step that takes cnt 1→0 writes the result; next state DONE.
  - DONE: out_valid=1. alu_out, zero, ovf and bad_op are held stable. When out_ready is high, next state IDLE.
- No overlap: in_ready is low in BUSY and DONE. in_valid held high there is not accepted.
- zero, ovf and bad_op are registered together with alu_out and are valid only while out_valid=1.

## Timing
- Reset, sampled low at an edge:
  - state ← IDLE; out_valid, alu_out, zero, ovf, bad_op ← 0; cnt ← 0.
  - in_ready is forced 0 while rst_n is low and goes 1 in the first cycle after release.
- Reset mid-BUSY or mid-DONE aborts the operation. The result is discarded and no out_valid pulse occurs.
- Accept edge = T0.
  - Single-cycle ops: out_valid high in cycle T0+1.
  - Multi-cycle ops: out_valid high in cycle T0+WIDTH+1.
- Out handshake at edge Tn with out_valid & out_ready: out_valid is low and in_ready high in cycle Tn+1.
  - Earliest next accept is edge Tn+1.
  - Throughput for single-cycle ops is therefore one op per 2 cycles.
- out_ready already high on the cycle out_valid rises gives a 1-cycle DONE.
- out_ready low holds DONE indefinitely with all outputs unchanged.
- in_ready and out_valid are decoded from state only, with no combinational path from in_valid/out_ready.
- Shift amount 0 returns alu_a unchanged. SRA fills with alu_a[WIDTH-1].

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 at T0 → alu_out=0x80000000, ovf=1, zero=0, out_valid in cycle T0+1. SUB 5−5 → 0, zero=1, ovf=0.
- SRA alu_a=0x80000000, alu_b=0x24 (shift 4) → 0xF8000000. SLL 1 by 31 → 0x80000000. SLT 0xFFFFFFFF vs 1 → 1; SLTU same operands → 0.
- MUL 0xFFFFFFFF × 3 → 0xFFFFFFFD. out_valid first high in cycle T0+33; in_ready=0 through cycles T0+1..T0+33; in_valid held high during BUSY is not accepted.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9; bad_op=0 throughout.
- Opcode 0x15 → alu_out=0, bad_op=1 at T0+1. Hold out_ready=0 for 5 cycles → outputs unchanged. Raise out_ready → in_ready=1 the following cycle.
- Start MUL, drive rst_n=0 at cycle T0+10 for one edge → out_valid stays 0, alu_out=0, in_ready=1 after release. A new ADD 2+3 then yields 5 with no stale MUL result.
